// File: rtl/player_pkg.sv
// player_pkg: state encoding and default widths shared by the beat player blocks.
package player_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  localparam int BEAT_W_DEF = 12;
endpackage

// File: rtl/beat_index_ctr.sv
// beat_index_ctr: song position counter with latched length, end-of-song compare,
// wrap-or-hold advance and saturating rewind.
module beat_index_ctr #(
  parameter int BEAT_W = player_pkg::BEAT_W_DEF,
  parameter int REWIND = 16
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [BEAT_W-1:0] i_len,
  input  logic              i_clr,
  input  logic              i_adv,
  input  logic              i_loop,
  input  logic              i_sub,
  output logic [BEAT_W-1:0] o_beat,
  output logic              o_at_end
);
  localparam logic [BEAT_W:0] REW = (BEAT_W+1)'(REWIND);
  logic [BEAT_W-1:0] r_beat, r_len, w_beat_nxt, w_rewound;
  logic [BEAT_W:0]   w_len_eff, w_inc;
  // one extra bit keeps the compare exact at the top of the index range
  assign w_len_eff = (r_len == '0) ? (BEAT_W+1)'(1) : {1'b0, r_len};
  assign w_inc     = {1'b0, r_beat} + (BEAT_W+1)'(1);
  assign o_at_end  = w_inc >= w_len_eff;
  assign w_rewound = ({1'b0, r_beat} >= REW) ? r_beat - REW[BEAT_W-1:0] : '0;
  always_comb
    w_beat_nxt = (i_load || i_clr) ? '0 :
                 i_sub             ? w_rewound :
                 i_adv             ? (o_at_end ? (i_loop ? '0 : r_beat) : w_inc[BEAT_W-1:0]) :
                                     r_beat;
  always_ff @(posedge clk or negedge i_reset)
    if (!i_reset) begin
      r_beat <= '0;
      r_len  <= '0;
    end else begin
      r_beat <= w_beat_nxt;
      if (i_load) r_len <= i_len;
    end
  assign o_beat = r_beat;
endmodule

// File: rtl/beat_sequencer.sv
// beat_sequencer: tick-driven song position FSM with loop/one-shot, pause, stop and rewind.
// Define COUNT_IN_EN to add a COUNT_IN-beat lead-in after every start.
module beat_sequencer
  import player_pkg::*;
#(
  parameter int BEAT_W   = BEAT_W_DEF,
  parameter int REWIND   = 16,
  parameter int LOOP_W   = 4,
  parameter int COUNT_IN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_beat_tick,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_pause,
  input  logic              i_seek_back,
  input  logic              i_loop_en,
  input  logic [BEAT_W-1:0] i_song_len,
  output logic [BEAT_W-1:0] o_ibeat,
  output logic [1:0]        o_state,
  output logic              o_playing,
  output logic              o_song_end,
  output logic              o_end_pulse,
  output logic [LOOP_W-1:0] o_loop_cnt,
  output logic              o_count_in
);
  typedef logic [$clog2(COUNT_IN+2)-1:0] lead_t;
  state_t            r_state, w_state_nxt;
  logic [LOOP_W-1:0] r_loop_cnt, w_loop_nxt;
  logic              r_playing, r_song_end, r_end_pulse, r_count_in;
  logic              w_playing_nxt, w_song_end_nxt;
  logic              w_start, w_live, w_active, w_lead_active, w_seek, w_adv, w_at_end, w_wrap, w_end;
  lead_t             w_lead, w_lead_nxt;
  // stop beats start; both pre-empt seek, which pre-empts a tick
  assign w_start       = i_start & ~i_stop;
  assign w_live        = ~i_start & ~i_stop;
  assign w_active      = (r_state == ST_PLAY) || (r_state == ST_PAUSE);
  assign w_lead_active = |w_lead;
  assign w_seek        = w_live & i_seek_back & w_active & ~w_lead_active;
  assign w_adv         = w_live & ~w_seek & i_beat_tick & (r_state == ST_PLAY) & ~i_pause & ~w_lead_active;
  assign w_wrap        = w_adv & w_at_end & i_loop_en;
  assign w_end         = w_adv & w_at_end & ~i_loop_en;
`ifdef COUNT_IN_EN
  lead_t r_lead;
  logic  w_lead_tick;
  assign w_lead_tick = w_live & i_beat_tick & (r_state == ST_PLAY) & ~i_pause & w_lead_active;
  assign w_lead      = r_lead;
  always_comb
    w_lead_nxt = i_stop      ? '0 :
                 w_start     ? lead_t'(COUNT_IN) :
                 w_lead_tick ? r_lead - lead_t'(1) :
                               r_lead;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) r_lead <= '0;
    else          r_lead <= w_lead_nxt;
`else
  assign w_lead     = '0;
  assign w_lead_nxt = '0;
`endif
  beat_index_ctr #(.BEAT_W(BEAT_W), .REWIND(REWIND)) u_ctr (
    .clk      (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_start),
    .i_len    (i_song_len),
    .i_clr    (i_stop),
    .i_adv    (w_adv),
    .i_loop   (i_loop_en),
    .i_sub    (w_seek),
    .o_beat   (o_ibeat),
    .o_at_end (w_at_end)
  );
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_loop_cnt  <= '0;
      r_playing   <= 1'b0;
      r_song_end  <= 1'b0;
      r_end_pulse <= 1'b0;
      r_count_in  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_loop_cnt  <= w_loop_nxt;
      r_playing   <= w_playing_nxt;
      r_song_end  <= w_song_end_nxt;
      r_end_pulse <= w_end;
      r_count_in  <= |w_lead_nxt;
    end
  always_comb
    w_state_nxt = i_stop                 ? ST_IDLE :
                  w_start                ? ST_PLAY :
                  (r_state == ST_PLAY)   ? (i_pause ? ST_PAUSE : (w_end ? ST_DONE : ST_PLAY)) :
                  (r_state == ST_PAUSE)  ? (i_pause ? ST_PAUSE : ST_PLAY) :
                                           r_state;
  always_comb begin
    w_playing_nxt  = w_state_nxt == ST_PLAY;
    w_song_end_nxt = w_state_nxt == ST_DONE;
    w_loop_nxt     = (i_stop || w_start)       ? '0 :
                     (w_wrap && ~&r_loop_cnt)  ? r_loop_cnt + LOOP_W'(1) :
                                                 r_loop_cnt;
  end
  assign o_state     = r_state;
  assign o_playing   = r_playing;
  assign o_song_end  = r_song_end;
  assign o_end_pulse = r_end_pulse;
  assign o_loop_cnt  = r_loop_cnt;
  assign o_count_in  = r_count_in;
endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: directed literal checks plus randomized traffic against a behavioural model.
module tb_beat_sequencer;
`ifdef COUNT_IN_EN
  localparam int CI = 4;
`else
  localparam int CI = 0;
`endif
  logic clk = 0, rst_n = 0;
  logic tick = 0, start = 0, stop = 0, pause = 0, seek = 0, loop_en = 0;
  logic [11:0] len = 0;
  logic [11:0] ibeat;
  logic [1:0]  state;
  logic        playing, song_end, end_pulse, count_in;
  logic [3:0]  loop_cnt;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  int m_state = 0, m_beat = 0, m_len = 0, m_loops = 0, m_endp = 0, m_lead = 0;

  always #5 clk = ~clk;

  beat_sequencer dut (
    .i_clk(clk), .i_reset(rst_n), .i_beat_tick(tick), .i_start(start), .i_stop(stop),
    .i_pause(pause), .i_seek_back(seek), .i_loop_en(loop_en), .i_song_len(len),
    .o_ibeat(ibeat), .o_state(state), .o_playing(playing), .o_song_end(song_end),
    .o_end_pulse(end_pulse), .o_loop_cnt(loop_cnt), .o_count_in(count_in)
  );

  // model: 0 IDLE, 1 PLAY, 2 PAUSE, 3 DONE; beats counted as plain integers
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_beat = 0; m_len = 0; m_loops = 0; m_endp = 0; m_lead = 0;
    end else if (stop) begin
      m_state = 0; m_beat = 0; m_loops = 0; m_endp = 0; m_lead = 0;
    end else if (start) begin
      m_state = 1; m_beat = 0; m_loops = 0; m_endp = 0; m_lead = CI;
      m_len = (len == 0) ? 1 : int'(len);
    end else begin
      m_endp = 0;
      if (m_state == 1 || m_state == 2) begin
        if (seek && m_lead == 0) m_beat = (m_beat >= 16) ? m_beat - 16 : 0;
        else if (m_state == 1 && tick && !pause) begin
          if (m_lead > 0) m_lead--;
          else if (m_beat < m_len - 1) m_beat++;
          else if (loop_en) begin m_beat = 0; m_loops = (m_loops < 15) ? m_loops + 1 : 15; end
          else begin m_state = 3; m_endp = 1; end
        end
        if (m_state != 3) m_state = pause ? 2 : 1;
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("ibeat", int'(ibeat), m_beat);
    check("state", int'(state), m_state);
    check("playing", int'(playing), int'(m_state == 1));
    check("song_end", int'(song_end), int'(m_state == 3));
    check("end_pulse", int'(end_pulse), m_endp);
    check("loop_cnt", int'(loop_cnt), m_loops);
    check("count_in", int'(count_in), int'(m_lead > 0));
  end

  task automatic step(input logic t, input logic s, input logic p, input logic ps,
                      input logic sk, input logic le, input logic [11:0] ln);
    tick = t; start = s; stop = p; pause = ps; seek = sk; loop_en = le; len = ln;
    @(negedge clk);
  endtask

  task automatic ticks(input int n, input logic le);
    repeat (n) step(1, 0, 0, 0, 0, le, 0);
  endtask

  task automatic go(input logic [11:0] ln, input logic le);
    step(0, 1, 0, 0, 0, le, ln);
    ticks(CI, le);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_ibeat", int'(ibeat), 0);
    check("rst_song_end", int'(song_end), 0);
    check("rst_loop_cnt", int'(loop_cnt), 0);
    rst_n = 1; chk_en = 1;
    go(5, 0);
    check("os_start_beat", int'(ibeat), 0);
    ticks(4, 0);
    check("os_beat4", int'(ibeat), 4);
    check("os_play", int'(state), 1);
    ticks(1, 0);
    check("os_done", int'(state), 3);
    check("os_pulse", int'(end_pulse), 1);
    check("os_hold", int'(ibeat), 4);
    ticks(1, 0);
    check("os_pulse_once", int'(end_pulse), 0);
    check("os_song_end", int'(song_end), 1);
    go(3, 1);
    ticks(7, 1);
    check("lp_beat", int'(ibeat), 1);
    check("lp_cnt", int'(loop_cnt), 2);
    check("lp_state", int'(state), 1);
    go(0, 1);
    ticks(20, 1);
    check("sat_cnt", int'(loop_cnt), 15);
    check("len0_beat", int'(ibeat), 0);
    go(100, 0);
    ticks(20, 0);
    check("sk_at20", int'(ibeat), 20);
    step(0, 0, 0, 0, 1, 0, 0);
    check("sk_to4", int'(ibeat), 4);
    step(0, 0, 0, 0, 1, 0, 0);
    check("sk_to0", int'(ibeat), 0);
    repeat (3) step(1, 0, 0, 1, 0, 0, 0);
    check("pz_state", int'(state), 2);
    check("pz_beat", int'(ibeat), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("pz_resume", int'(state), 1);
    step(0, 1, 1, 0, 0, 0, 9);
    check("ss_state", int'(state), 0);
    check("ss_beat", int'(ibeat), 0);
    step(1, 1, 0, 0, 0, 0, 9);
    check("st_tick_beat", int'(ibeat), 0);
    check("st_tick_state", int'(state), 1);
`ifdef COUNT_IN_EN
    step(0, 1, 0, 0, 0, 0, 10);
    for (int k = 1; k <= 4; k++) begin
      check("ci_high", int'(count_in), 1);
      ticks(1, 0);
      check("ci_beat0", int'(ibeat), 0);
    end
    check("ci_low", int'(count_in), 0);
    ticks(1, 0);
    check("ci_first", int'(ibeat), 1);
`endif
    go(50, 0);
    ticks(7, 0);
    check("ar_at7", int'(ibeat), 7);
    @(posedge clk); #3 rst_n = 0;
    #1;
    check("ar_beat", int'(ibeat), 0);
    check("ar_state", int'(state), 0);
    check("ar_playing", int'(playing), 0);
    @(negedge clk); rst_n = 1;
    ticks(3, 0);
    check("ar_idle_beat", int'(ibeat), 0);
    check("ar_idle_state", int'(state), 0);
    for (int i = 0; i < 3000; i++)
      step($urandom % 100 < 50, $urandom % 100 < 3, $urandom % 100 < 2, $urandom % 100 < 20,
           $urandom % 100 < 6, $urandom % 100 < 70, 12'($urandom_range(0, (i < 1500) ? 6 : 40)));
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
Parametrised beat-position sequencer, successor to the single-purpose beat counter. Drives the song ROM beat index for both free-play and game modes from one FSM. Adds tick-gated advance, per-song length latched at start, loop/one-shot selection, pause, stop, rewind-seek and a loop counter. Sits between the tempo clock divider (beat_tick) and the note ROM / scoring logic.

Parameters:
BEAT_W, 12, width of beat index and song length
REWIND, 16, beats stepped back per seek_back pulse
LOOP_W, 4, width of loop counter
COUNT_IN, 4, lead-in beats before beat 0 (used only with COUNT_IN_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
beat_tick  in  1  one-cycle strobe, one per beat; advance only on tick
start  in  1  pulse: begin/restart song from beat 0
stop  in  1  pulse: abort to IDLE
pause  in  1  level: hold position while high
seek_back  in  1  pulse: rewind REWIND beats
loop_en  in  1  1 = wrap at end (free play), 0 = one-shot (game)
song_len  in  BEAT_W  song length in beats, sampled on start
ibeat  out  BEAT_W  current beat index
state  out  2  IDLE=0, PLAY=1, PAUSE=2, DONE=3
playing  out  1  high in PLAY
song_end  out  1  level, high in DONE
end_pulse  out  1  one-cycle pulse on entering DONE
loop_cnt  out  LOOP_W  completed loops since start, saturating
count_in  out  1  high during lead-in (0 when COUNT_IN_EN undefined)

Behaviour:
- Reset (reset=0, async): state=IDLE, ibeat=0, len_q=0, loop_cnt=0, song_end=0, end_pulse=0, count_in=0. All outputs registered.
- Command priority per cycle: stop > start > seek_back > beat_tick.
- stop: any state -> IDLE, ibeat=0, loop_cnt=0, next cycle.
- start: any state -> PLAY; ibeat=0; loop_cnt=0; len_q <= song_len. A tick in the same cycle is ignored (first advance needs a later tick).
- len_q==0 treated as 1. With len 1, ibeat stays 0.
- PLAY, beat_tick, ibeat < len_q-1: ibeat+1.
- PLAY, beat_tick, ibeat == len_q-1: loop_en=1 -> ibeat=0, loop_cnt+1 (saturate at all-ones), stay PLAY; loop_en=0 -> DONE, ibeat holds len_q-1, end_pulse=1 for one cycle.
- loop_en is sampled at the wrap point, not at start.
- PLAY with pause=1 -> PAUSE next cycle; the tick that cycle is ignored. PAUSE with pause=0 -> PLAY. Ticks are ignored in PAUSE.
- seek_back in PLAY/PAUSE: ibeat = (ibeat >= REWIND) ? ibeat-REWIND : 0. State unchanged. Ignored in IDLE/DONE.
- DONE: holds until start or stop. song_end=1.
- IDLE: ibeat=0. Ticks, pause and seek are ignored.
- Arithmetic is done in BEAT_W+1 bits internally; no silent wrap of ibeat.

Optional Feature:
COUNT_IN_EN. Defined: start enters PLAY with count_in=1 and an internal lead-in counter set to COUNT_IN. Each tick decrements the counter while ibeat is held at 0. On the tick where the counter reaches 0, count_in drops and normal advance begins on the next tick. pause and stop apply during lead-in. seek_back during lead-in is ignored. Undefined: count_in is tied to 0 and start advances directly.

Decomposition:
- Shared package player_pkg: state encoding constants ST_IDLE, ST_PLAY, ST_PAUSE, ST_DONE, and default BEAT_W.
- One natural sub-module, beat_index_ctr: loadable up-counter with saturating subtract and wrap compare. The FSM stays in beat_sequencer.

Test Plan:
- song_len=5, loop_en=0, start, 6 ticks -> ibeat 0,1,2,3,4 then DONE with ibeat=4; end_pulse exactly 1 cycle; song_end=1.
- song_len=3, loop_en=1, start, 7 ticks -> ibeat 1,2,0,1,2,0,1; loop_cnt=2; state stays PLAY.
- At ibeat=20, seek_back -> ibeat=4. Then seek_back -> ibeat=0. pause=1 with 3 ticks -> ibeat unchanged, state=PAUSE.
- start and stop in the same cycle -> IDLE, ibeat=0. start plus tick in the same cycle -> ibeat=0.
- Assert reset mid-PLAY at ibeat=7, async and not clock-aligned -> outputs reset immediately. After release, ticks do not advance ibeat (IDLE).
- COUNT_IN_EN, COUNT_IN=4: start, 5 ticks -> count_in high for 4 ticks with ibeat=0; 5th tick gives ibeat=1.
